// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core front end.
//   XLEN          default address/instruction width
//   NOP_INSN      canonical NOP (addi x0, x0, 0) shown when nothing is presented
//   fetch_entry_t {pc, ins} pair held in the prefetch buffer
//   redirect_t    {valid, pc} taken-branch redirect from EX
//   align_word()  clears the byte-offset bits of an address
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_entry_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
    } redirect_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used by the fetch unit, both as the prefetch buffer and
// as the queue of PCs belonging to outstanding memory requests.
//   clk, rst      clock, synchronous active-high reset
//   push, din     write an entry (ignored when full unless a pop frees a slot)
//   pop, dout     dout is the head entry; pop advances the head when not empty
//   flush         empties the FIFO; takes priority over push and pop
//   count         number of stored entries (0..DEPTH)
//   full, empty   status flags derived from count
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[head];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Credit-controlled instruction fetch stage.
// Issues in-order fetches to instruction memory, buffers the returned
// instructions in a DEPTH-entry prefetch FIFO and presents them to IF/ID.
// Taken-branch redirects flush the buffer and drop responses that belong to
// requests issued before the redirect.
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_valid/ready, addr    fetch request handshake
//   imem_rsp_valid, rsp_data      in-order responses from memory
//   redirect_valid, redirect_pc   taken branch from EX (target word-aligned here)
//   if_valid/ready, if_pc, if_ins delivery handshake to IF/ID
//   perf_fetched, perf_flushes    instructions delivered / redirects seen
//                                 (present only when FETCH_PERF_EN is defined)
// XLEN overrides must match riscv_pkg::XLEN, which sizes the shared structs.
module fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_ins
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushes
`endif
);

    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    redirect_t       redir;
    fetch_entry_t    pf_din;
    fetch_entry_t    pf_dout;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pcq_dout;
    logic [CW-1:0]   pf_count;
    logic [CW-1:0]   pcq_count;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discard_n;
    logic [CW-1:0]   out_next;
    logic            pf_push, pf_pop, pf_full, pf_empty;
    logic            pcq_full, pcq_empty;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_accept;

    assign redir = {redirect_valid, align_word(redirect_pc)};

    // Credit counts both buffered and in-flight fetches, using registered
    // occupancy only so if_ready never reaches the request path.
    assign credit_ok      = ({1'b0, pf_count} + {1'b0, pcq_count}) < (CW+1)'(DEPTH);
    assign imem_req_valid = !rst && !redir.valid && credit_ok && !pcq_full;
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding belongs to a request from before
    // reset and is ignored.
    assign rsp_accept = imem_rsp_valid && !pcq_empty && !rst;

    assign pf_push = rsp_accept && (discard == '0);
    assign pf_din  = {pcq_dout, imem_rsp_data};
    assign pf_pop  = if_valid && if_ready;

    assign if_valid = !pf_empty && !redir.valid;
    assign if_pc    = pf_empty ? '0 : pf_dout.pc;
    assign if_ins   = pf_empty ? XLEN'(NOP_INSN) : pf_dout.ins;

    // Everything still in flight after a redirect cycle is stale; a response
    // landing in the redirect cycle itself is lost to the flush.
    assign out_next = pcq_count + CW'(req_fire) - CW'(rsp_accept);

    always_comb begin
        discard_n = discard;
        if (rsp_accept && (discard != '0)) discard_n = discard - CW'(1);
        if (redir.valid)                   discard_n = out_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else begin
            discard <= discard_n;
            if (redir.valid)   fetch_pc <= redir.pc;
            else if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_pf (
        .clk   (clk),
        .rst   (rst),
        .push  (pf_push),
        .pop   (pf_pop),
        .flush (redir.valid),
        .din   (pf_din),
        .dout  (pf_dout),
        .count (pf_count),
        .full  (pf_full),
        .empty (pf_empty)
    );

    // PCs of outstanding requests; never flushed, since every request still
    // gets a response that must be matched (and possibly discarded).
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pcq (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (rsp_accept),
        .flush (1'b0),
        .din   (fetch_pc),
        .dout  (pcq_dout),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (pf_pop)      perf_fetched <= perf_fetched + 32'd1;
            if (redir.valid) perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule
